// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port codes, flit type codes, header field offsets.
package router_pkg;

  localparam logic [2:0] PORT_NORTH = 3'b001;
  localparam logic [2:0] PORT_SOUTH = 3'b010;
  localparam logic [2:0] PORT_WEST  = 3'b011;
  localparam logic [2:0] PORT_EAST  = 3'b100;
  localparam logic [2:0] PORT_LOCAL = 3'b101;

  typedef enum logic [1:0] {
    FT_HEADTAIL = 2'b00,
    FT_HEAD     = 2'b01,
    FT_BODY     = 2'b10,
    FT_TAIL     = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_ACTIVE
  } ibuf_state_e;

  // Field positions, counted downward from the flit MSB.
  localparam int TYPE_W     = 2;
  localparam int DEST_X_OFS = 2;
  localparam int DEST_Y_OFS = 5;

  function automatic logic is_head(input logic [1:0] t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return (t == FT_TAIL) || (t == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit storage for one router input: circular buffer with wrap-around pointers and occupancy count.
module flit_fifo
  import router_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_pop,
  output logic [FLIT_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/input_port_buffer.sv
// Router input stage: buffers flits, looks up the route of each head flit, then streams the packet to the switch.
module input_port_buffer
  import router_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] router_address_x,
  input  logic [ADDR_W-1:0] router_address_y,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic [ADDR_W-1:0] flit_desn_x,
  output logic [ADDR_W-1:0] flit_desn_y,
  output logic              read_request,
  input  logic [2:0]        next_hop,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [2:0]        out_port,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_drop
);

  ibuf_state_e       r_state;
  ibuf_state_e       w_state_nxt;
  logic [2:0]        r_out_port;
  logic              r_err_drop;
  logic [FLIT_W-1:0] w_head;
  logic [1:0]        w_head_type;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_is_local;

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_flit),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign in_ready    = !w_full;
  assign w_push      = in_valid && in_ready;
  assign w_head_type = w_head[FLIT_W-1 -: TYPE_W];
  assign flit_desn_x = w_head[FLIT_W-1-DEST_X_OFS -: ADDR_W];
  assign flit_desn_y = w_head[FLIT_W-1-DEST_Y_OFS -: ADDR_W];
  assign w_is_local  = (flit_desn_x == router_address_x) && (flit_desn_y == router_address_y);
  assign out_flit    = w_head;
  assign out_port    = r_out_port;
  assign err_drop    = r_err_drop;
  assign busy        = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    read_request = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (is_head(w_head_type)) begin
            w_state_nxt = ST_ROUTE;
          end else begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        read_request = 1'b1;
        w_state_nxt  = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        out_valid = !w_empty;
        if (out_valid && out_ready) begin
          w_pop = 1'b1;
          if (is_tail(w_head_type)) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_out_port <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_drop <= w_drop;
      // The routing table has no code for this router itself.
      if (r_state == ST_ROUTE) r_out_port <= w_is_local ? PORT_LOCAL : next_hop;
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (2,2): routing, latency, backpressure, stray drop, reset.
module tb_input_port_buffer;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rx, ry;
  logic        in_valid;
  logic [15:0] in_flit;
  logic        in_ready;
  logic [2:0]  flit_desn_x, flit_desn_y;
  logic        read_request;
  logic [2:0]  next_hop;
  logic        out_valid;
  logic [15:0] out_flit;
  logic [2:0]  out_port;
  logic        out_ready;
  logic        busy;
  logic        err_drop;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_a [8];
  logic [15:0] fifth;
  bit          acc_seen;

  always #5 clk = ~clk;

  input_port_buffer #(.FLIT_W(16), .DEPTH(4), .ADDR_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .router_address_x (rx),
    .router_address_y (ry),
    .in_valid         (in_valid),
    .in_flit          (in_flit),
    .in_ready         (in_ready),
    .flit_desn_x      (flit_desn_x),
    .flit_desn_y      (flit_desn_y),
    .read_request     (read_request),
    .next_hop         (next_hop),
    .out_valid        (out_valid),
    .out_flit         (out_flit),
    .out_port         (out_port),
    .out_ready        (out_ready),
    .busy             (busy),
    .err_drop         (err_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [2:0] x,
                                     input logic [2:0] y, input logic [7:0] pl);
    return {t, x, y, pl};
  endfunction

  // Call mid-cycle; collects n popped flits against exp_a and releases a pending input once accepted.
  task automatic drain(input string tag, input int n, input logic [2:0] port);
    int idx;
    bit rel;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < n; cyc++) begin
      #1;
      rel = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk({tag, "_flit"}, 32'(out_flit), 32'(exp_a[idx]));
        chk({tag, "_port"}, 32'(out_port), 32'(port));
        idx++;
      end
      @(posedge clk);
      #1;
      if (rel) begin
        in_valid = 1'b0;
        acc_seen = 1'b1;
      end
    end
    chk({tag, "_count"}, 32'(idx), 32'(n));
  endtask

  initial begin
    rst_n = 1'b0; rx = 3'd2; ry = 3'd2;
    in_valid = 1'b0; in_flit = '0; next_hop = '0; out_ready = 1'b0; acc_seen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_req", 32'(read_request), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);

    // Single HEADTAIL to (4,2): latency and SOUTH routing.
    out_ready = 1'b1; next_hop = PORT_SOUTH;
    in_flit = mk(FT_HEADTAIL, 3'd4, 3'd2, 8'h5A); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t1_rr_idle", 32'(read_request), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("t1_rr_route", 32'(read_request), 32'd1);
    chk("t1_desn_x", 32'(flit_desn_x), 32'd4);
    chk("t1_desn_y", 32'(flit_desn_y), 32'd2);
    chk("t1_ov_route", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("t1_ov_active", 32'(out_valid), 32'd1);
    chk("t1_port", 32'(out_port), 32'(PORT_SOUTH));
    chk("t1_flit", 32'(out_flit), 32'(mk(FT_HEADTAIL, 3'd4, 3'd2, 8'h5A)));
    chk("t1_busy_active", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk("t1_ov_after", 32'(out_valid), 32'd0);

    // Four-flit packet to (2,5): EAST held across the packet.
    out_ready = 1'b0; next_hop = PORT_EAST;
    exp_a[0] = mk(FT_HEAD, 3'd2, 3'd5, 8'h11);
    exp_a[1] = mk(FT_BODY, 3'd7, 3'd1, 8'h22);
    exp_a[2] = mk(FT_BODY, 3'd0, 3'd6, 8'h33);
    exp_a[3] = mk(FT_TAIL, 3'd5, 3'd3, 8'h44);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_flit = exp_a[i];
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; next_hop = PORT_NORTH;
    drain("t2", 4, PORT_EAST);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Head addressed to this router: LOCAL despite next_hop NORTH.
    @(negedge clk); next_hop = PORT_NORTH;
    exp_a[0] = mk(FT_HEADTAIL, 3'd2, 3'd2, 8'hC3);
    in_flit = exp_a[0]; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    drain("t3", 1, PORT_LOCAL);

    // Backpressure: fifth flit held off until the full FIFO drains.
    out_ready = 1'b0; next_hop = PORT_WEST;
    exp_a[0] = mk(FT_HEAD, 3'd1, 3'd2, 8'hA1);
    exp_a[1] = mk(FT_BODY, 3'd1, 3'd2, 8'hA2);
    exp_a[2] = mk(FT_BODY, 3'd1, 3'd2, 8'hA3);
    exp_a[3] = mk(FT_TAIL, 3'd1, 3'd2, 8'hA4);
    fifth    = mk(FT_HEADTAIL, 3'd0, 3'd2, 8'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_flit = (i < 4) ? exp_a[i] : fifth; #1;
      chk("t4_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) @(posedge clk);
    end
    chk("t4_out_valid_full", 32'(out_valid), 32'd1);
    acc_seen = 1'b0; out_ready = 1'b1;
    drain("t4a", 4, PORT_WEST);
    chk("t4_fifth_accepted", 32'(acc_seen), 32'd1);
    in_valid = 1'b0;
    exp_a[0] = fifth;
    drain("t4b", 1, PORT_WEST);

    // Stray BODY while idle is dropped; following head routes normally.
    @(negedge clk); next_hop = PORT_NORTH; out_ready = 1'b1;
    in_valid = 1'b1; in_flit = mk(FT_BODY, 3'd3, 3'd3, 8'hEE);
    @(posedge clk);
    @(negedge clk); in_flit = mk(FT_HEADTAIL, 3'd2, 3'd0, 8'h42); #1;
    chk("t5_err_before", 32'(err_drop), 32'd0);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t5_err_pulse", 32'(err_drop), 32'd1);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("t5_err_cleared", 32'(err_drop), 32'd0);
    exp_a[0] = mk(FT_HEADTAIL, 3'd2, 3'd0, 8'h42);
    drain("t5", 1, PORT_NORTH);

    // Reset with three flits of an open packet buffered.
    out_ready = 1'b0; next_hop = PORT_EAST;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1;
      in_flit = (i == 0) ? mk(FT_HEAD, 3'd2, 3'd6, 8'h01) : mk(FT_BODY, 3'd0, 3'd0, 8'(i));
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_ov_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_ov_rst", 32'(out_valid), 32'd0);
    chk("t6_in_ready_rst", 32'(in_ready), 32'd1);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_port_rst", 32'(out_port), 32'd0);
    @(negedge clk); rst_n = 1'b1; next_hop = PORT_WEST; out_ready = 1'b1;
    exp_a[0] = mk(FT_HEADTAIL, 3'd3, 3'd1, 8'h77);
    in_flit = exp_a[0]; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    drain("t6", 1, PORT_WEST);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
